// File: rtl/register_scoreboard.sv
// Per-register in-flight writer counters between decode and writeback.
// Produces read-after-write contention, issue stall and a sticky protocol error.
module register_scoreboard #(
  parameter int NUM_REGISTERS           = 32,
  parameter int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS),
  parameter int MAX_IN_FLIGHT           = 3,
  parameter int COUNT_WIDTH             = $clog2(MAX_IN_FLIGHT + 1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] register_read_1,
  output logic                               register_read_1_contended,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] register_read_2,
  output logic                               register_read_2_contended,
  input  logic                               issue_valid,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] issue_register,
  output logic                               issue_stall,
  input  logic                               retire_valid,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] retire_register,
  input  logic                               squash_valid,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] squash_register,
  output logic                               any_pending,
  output logic                               protocol_error
);

  typedef logic [COUNT_WIDTH-1:0] count_t;

  count_t count_q [NUM_REGISTERS];
  count_t count_d [NUM_REGISTERS];
  logic   error_q, error_d;

  logic [NUM_REGISTERS-1:0] issue_hit, retire_hit, squash_hit;
  logic                     read_1_busy, read_2_busy, stall_state, pending_q;

  // Register 0 never produces a hit, so its counter stays at zero forever.
  always_comb begin
    issue_hit  = '0;
    retire_hit = '0;
    squash_hit = '0;
    if (issue_valid && issue_register != '0)
      issue_hit[issue_register] = 1'b1;
    if (retire_valid && retire_register != '0)
      retire_hit[retire_register] = 1'b1;
    if (squash_valid && squash_register != '0)
      squash_hit[squash_register] = 1'b1;
  end

  // Same-cycle decrements resolve the hazard because the register file is write-through.
  assign read_1_busy = (register_read_1 != '0) &&
                       (int'(count_q[register_read_1]) >
                        int'(retire_hit[register_read_1]) + int'(squash_hit[register_read_1]));
  assign read_2_busy = (register_read_2 != '0) &&
                       (int'(count_q[register_read_2]) >
                        int'(retire_hit[register_read_2]) + int'(squash_hit[register_read_2]));
  assign stall_state = (issue_register != '0) &&
                       (int'(count_q[issue_register]) -
                        int'(retire_hit[issue_register]) - int'(squash_hit[issue_register])
                        >= MAX_IN_FLIGHT);

  always_comb begin
    pending_q = 1'b0;
    for (int r = 1; r < NUM_REGISTERS; r++)
      pending_q = pending_q | (count_q[r] != '0);
  end

  assign register_read_1_contended = rst_n && read_1_busy;
  assign register_read_2_contended = rst_n && read_2_busy;
  assign issue_stall               = !rst_n || stall_state;
  assign any_pending               = rst_n && pending_q;
  assign protocol_error            = error_q;

  always_comb begin
    int nxt;
    nxt     = 0;
    error_d = error_q;
    for (int r = 0; r < NUM_REGISTERS; r++) begin
      count_d[r] = count_q[r];
      if (r != 0) begin
        nxt = int'(count_q[r]) + int'(issue_hit[r]) - int'(retire_hit[r]) - int'(squash_hit[r]);
        if (nxt > MAX_IN_FLIGHT) begin
          count_d[r] = COUNT_WIDTH'(MAX_IN_FLIGHT);
          error_d    = 1'b1;
        end else if (nxt < 0) begin
          count_d[r] = '0;
          error_d    = 1'b1;
        end else begin
          count_d[r] = COUNT_WIDTH'(nxt);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGISTERS; r++)
        count_q[r] <= '0;
      error_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGISTERS; r++)
        count_q[r] <= count_d[r];
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard with immediate-assertion checks.
module tb_register_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] register_read_1, register_read_2;
  logic       register_read_1_contended, register_read_2_contended;
  logic       issue_valid, retire_valid, squash_valid;
  logic [4:0] issue_register, retire_register, squash_register;
  logic       issue_stall, any_pending, protocol_error;

  int checks = 0;
  int errors = 0;

  register_scoreboard dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .register_read_1           (register_read_1),
    .register_read_1_contended (register_read_1_contended),
    .register_read_2           (register_read_2),
    .register_read_2_contended (register_read_2_contended),
    .issue_valid               (issue_valid),
    .issue_register            (issue_register),
    .issue_stall               (issue_stall),
    .retire_valid              (retire_valid),
    .retire_register           (retire_register),
    .squash_valid              (squash_valid),
    .squash_register           (squash_register),
    .any_pending               (any_pending),
    .protocol_error            (protocol_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid  = 1'b0;
    retire_valid = 1'b0;
    squash_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    issue_register = 5'd5; retire_register = 5'd0; squash_register = 5'd0;
    register_read_1 = 5'd5; register_read_2 = 5'd5;
    #2;
    check("rst_stall", 32'(issue_stall), 1);
    check("rst_cont1", 32'(register_read_1_contended), 0);
    check("rst_pending", 32'(any_pending), 0);
    cyc(); cyc();
    check("rst_held_stall", 32'(issue_stall), 1);
    check("rst_error", 32'(protocol_error), 0);
    rst_n = 1'b1;
    #1;
    check("idle_stall_r5", 32'(issue_stall), 0);
    check("idle_cont1", 32'(register_read_1_contended), 0);
    check("idle_cont2", 32'(register_read_2_contended), 0);
    check("idle_pending", 32'(any_pending), 0);

    // RAW hazard on r5
    issue_valid = 1'b1; issue_register = 5'd5;
    #1;
    check("raw_same_cycle", 32'(register_read_1_contended), 0);
    cyc(); idle();
    #1;
    check("raw_t1", 32'(register_read_1_contended), 1);
    check("raw_t1_pending", 32'(any_pending), 1);
    cyc();
    check("raw_t2", 32'(register_read_1_contended), 1);
    cyc();
    check("raw_t3", 32'(register_read_1_contended), 1);
    cyc();
    retire_valid = 1'b1; retire_register = 5'd5;
    #1;
    check("raw_t4_retire", 32'(register_read_1_contended), 0);
    check("raw_t4_pending", 32'(any_pending), 1);
    cyc(); idle();
    #1;
    check("raw_t5_cont", 32'(register_read_1_contended), 0);
    check("raw_t5_pending", 32'(any_pending), 0);

    // Saturation on r7
    issue_valid = 1'b1; issue_register = 5'd7;
    cyc(); cyc(); cyc();
    check("sat_stall", 32'(issue_stall), 1);
    check("sat_no_err_yet", 32'(protocol_error), 0);
    check("sat_count3", 32'(dut.count_q[7]), 3);
    cyc(); idle();
    #1;
    check("ovf_error", 32'(protocol_error), 1);
    check("ovf_count", 32'(dut.count_q[7]), 3);
    retire_valid = 1'b1; retire_register = 5'd7;
    #1;
    check("stall_release_on_retire", 32'(issue_stall), 0);
    cyc(); cyc(); cyc(); idle();
    #1;
    check("sat_drained", 32'(dut.count_q[7]), 0);
    check("sat_drained_pending", 32'(any_pending), 0);

    // Same-cycle combos on r9
    issue_valid = 1'b1; issue_register = 5'd9;
    cyc(); cyc();
    retire_valid = 1'b1; retire_register = 5'd9;
    cyc(); idle();
    #1;
    check("iss_ret_net0", 32'(dut.count_q[9]), 2);
    retire_valid = 1'b1; retire_register = 5'd9;
    squash_valid = 1'b1; squash_register = 5'd9;
    register_read_2 = 5'd9;
    #1;
    check("ret_sq_uncontended", 32'(register_read_2_contended), 0);
    cyc(); idle();
    #1;
    check("ret_sq_count0", 32'(dut.count_q[9]), 0);
    check("err_sticky", 32'(protocol_error), 1);

    // Reset mid-flight on r4 and r6
    issue_valid = 1'b1; issue_register = 5'd4;
    cyc();
    issue_register = 5'd6;
    cyc(); idle();
    register_read_1 = 5'd4; register_read_2 = 5'd6;
    #1;
    check("mid_cont4", 32'(register_read_1_contended), 1);
    check("mid_cont6", 32'(register_read_2_contended), 1);
    rst_n = 1'b0;
    issue_valid = 1'b1; issue_register = 5'd4;
    #1;
    check("mid_rst_cont4", 32'(register_read_1_contended), 0);
    check("mid_rst_stall", 32'(issue_stall), 1);
    check("mid_rst_pending", 32'(any_pending), 0);
    cyc(); idle();
    rst_n = 1'b1;
    #1;
    check("post_rst_cont4", 32'(register_read_1_contended), 0);
    check("post_rst_cont6", 32'(register_read_2_contended), 0);
    check("post_rst_pending", 32'(any_pending), 0);
    check("post_rst_error", 32'(protocol_error), 0);

    // Register 0 ignored, then underflow on r3
    issue_valid = 1'b1;  issue_register = 5'd0;
    retire_valid = 1'b1; retire_register = 5'd0;
    squash_valid = 1'b1; squash_register = 5'd0;
    register_read_1 = 5'd0; register_read_2 = 5'd0;
    #1;
    check("r0_cont1", 32'(register_read_1_contended), 0);
    check("r0_cont2", 32'(register_read_2_contended), 0);
    check("r0_stall", 32'(issue_stall), 0);
    cyc(); idle();
    #1;
    check("r0_pending", 32'(any_pending), 0);
    check("r0_error", 32'(protocol_error), 0);
    retire_valid = 1'b1; retire_register = 5'd3;
    cyc(); idle();
    #1;
    check("udf_error", 32'(protocol_error), 1);
    check("udf_count", 32'(dut.count_q[3]), 0);
    cyc(); cyc();
    check("udf_sticky", 32'(protocol_error), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
